// File: rtl/int_to_float_pkg.sv
// Shared types for the int-to-float converter arbiter.
//   float_bits_t : IEEE-754 single-precision bit pattern
//   int_bits_t   : signed 32-bit operand
//   tag_t        : {valid, requester id} carried beside the converter pipeline
//   FLOAT_ONE    : bit pattern of 1.0f
package int_to_float_pkg;

  // Requester ids are sized for the largest supported NUM_REQ (8).
  localparam int ID_W = 3;

  typedef logic        [31:0] float_bits_t;
  typedef logic signed [31:0] int_bits_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  localparam float_bits_t FLOAT_ONE = 32'h3F800000;

endpackage

// File: rtl/int_to_float_rsp_fifo.sv
// Single-clock response FIFO holding converter results for one requester.
// Ports:
//   clk, reset     clock, synchronous active-low reset (empties the FIFO)
//   push/push_data write a result (never issued while full without a pop)
//   pop            consume the head; ignored while empty
//   valid/head     FIFO non-empty / head entry
module int_to_float_rsp_fifo
  import int_to_float_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  float_bits_t push_data,
  input  logic        pop,
  output logic        valid,
  output float_bits_t head
);

  // One extra pointer bit distinguishes full from empty when the indices match.
  localparam int AW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] MSB_ONLY = AW'(1) << (AW - 1);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [IW-1:0] wr_addr, rd_addr;
  logic          empty, full, do_pop, do_push;
  float_bits_t   mem [DEPTH];

  assign wr_addr = (DEPTH > 1) ? wr_ptr[IW-1:0] : '0;
  assign rd_addr = (DEPTH > 1) ? rd_ptr[IW-1:0] : '0;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = ((wr_ptr ^ rd_ptr) == MSB_ONLY);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign valid   = !empty;
  assign head    = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are meaningful, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_addr] <= push_data;
  end

  // The credit limit upstream guarantees a slot for every result.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
                                  !(push && full && !do_pop));

endmodule

// File: rtl/int_to_float_arbiter.sv
// Round-robin front end sharing one pipelined int-to-float converter among
// NUM_REQ requesters. A {valid, id} tag travels beside the converter for
// LATENCY cycles and steers each result into that requester's response FIFO.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   req_valid/req_data/req_ready  operand handshake per requester (one-hot grant)
//   rsp_valid/rsp_data/rsp_ready  response FIFO heads and pops per requester
//   conv_a / conv_result       operand to / result from the external converter
// Optional (macro INT_TO_FLOAT_ARB_PERF_EN):
//   perf_issue                 saturating count of cycles with a grant
//   perf_block                 saturating count of cycles with requests but no grant
module int_to_float_arbiter
  import int_to_float_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 3,
  parameter int DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [NUM_REQ*32-1:0] rsp_data,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output int_bits_t             conv_a,
  input  float_bits_t           conv_result
`ifdef INT_TO_FLOAT_ARB_PERF_EN
  ,
  output logic [31:0]           perf_issue,
  output logic [31:0]           perf_block
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0] eligible, grant, fifo_valid;
  logic               any_grant;
  logic [ID_W-1:0]    grant_id, ptr;
  int_bits_t          grant_data, last_a;
  tag_t               tag_q [LATENCY];
  int                 scan_idx;

  // Round-robin scan starting at ptr; first eligible requester wins.
  // NOTE: every output of this block gets a default before the loop so no
  // path leaves a variable unassigned (which would infer a latch).
  always_comb begin
    grant      = '0;
    any_grant  = 1'b0;
    grant_id   = '0;
    grant_data = '0;
    scan_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // NOTE: blocking assignments here are intentional: later iterations must
      // see any_grant already set by earlier ones within the same evaluation.
      scan_idx = int'(ptr) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (reset && !any_grant && eligible[scan_idx]) begin
        any_grant       = 1'b1;
        grant[scan_idx] = 1'b1;
        grant_id        = ID_W'(scan_idx);
        grant_data      = req_data[32*scan_idx +: 32];
      end
    end
  end

  assign req_ready = grant;
  // Idle cycles hold the last operand so the converter input does not toggle.
  assign conv_a    = !reset ? '0 : (any_grant ? grant_data : last_a);

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr    <= '0;
      last_a <= '0;
    end else if (any_grant) begin
      ptr    <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
      last_a <= grant_data;
    end
  end

  // Tag pipeline mirrors the converter latency; it never stalls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < LATENCY; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= '{valid: any_grant, id: grant_id};
      for (int s = 1; s < LATENCY; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    logic             push, pop;
    logic [CNT_W-1:0] outstanding;   // in-flight tags plus FIFO occupancy

    assign push        = tag_q[LATENCY-1].valid && (tag_q[LATENCY-1].id == ID_W'(i));
    assign pop         = rsp_valid[i] && rsp_ready[i];
    assign eligible[i] = req_valid[i] && (outstanding < DEPTH_C);

    always_ff @(posedge clk) begin
      if (!reset) begin
        outstanding <= '0;
      end else begin
        case ({grant[i], pop})
          2'b10:   outstanding <= outstanding + 1'b1;
          2'b01:   outstanding <= outstanding - 1'b1;
          default: outstanding <= outstanding;
        endcase
      end
    end

    int_to_float_rsp_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (conv_result),
      .pop       (pop),
      .valid     (fifo_valid[i]),
      .head      (rsp_data[32*i +: 32])
    );
  end

  assign rsp_valid = fifo_valid & {NUM_REQ{reset}};

`ifdef INT_TO_FLOAT_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_issue <= '0;
      perf_block <= '0;
    end else begin
      if (any_grant && (perf_issue != '1))               perf_issue <= perf_issue + 1'b1;
      if ((|req_valid) && !any_grant && (perf_block != '1)) perf_block <= perf_block + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_int_to_float_arbiter.sv
// Self-checking bench for int_to_float_arbiter: behavioural converter model,
// per-requester scoreboard queues, table-driven vectors and directed sequences.
// Define INT_TO_FLOAT_ARB_PERF_EN to also exercise the performance counters.
module tb_int_to_float_arbiter;
  import int_to_float_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int LAT     = 3;
  localparam int DEPTH   = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NUM_REQ*32-1:0] req_data, rsp_data;
  int_bits_t             conv_a;
  float_bits_t           conv_result;
`ifdef INT_TO_FLOAT_ARB_PERF_EN
  logic [31:0]           perf_issue, perf_block;
`endif

  int checks = 0;
  int errors = 0;

  int_to_float_arbiter #(.NUM_REQ(NUM_REQ), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_ready   (rsp_ready),
    .conv_a      (conv_a),
    .conv_result (conv_result)
`ifdef INT_TO_FLOAT_ARB_PERF_EN
    ,
    .perf_issue  (perf_issue),
    .perf_block  (perf_block)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference int -> float conversion, round to nearest even.
  function automatic float_bits_t i2f(input int_bits_t x);
    longint mag, mant, rem, half;
    int     p, s;
    logic   sign;
    if (x == 0) return '0;
    sign = (x < 0);
    mag  = x;
    if (sign) mag = -mag;
    p = 0;
    for (int b = 0; b < 33; b++) if (mag >= (longint'(1) << b)) p = b;
    if (p <= 23) begin
      mant = mag << (23 - p);
    end else begin
      s    = p - 23;
      mant = mag >> s;
      rem  = mag - (mant << s);
      half = longint'(1) << (s - 1);
      if (rem > half || (rem == half && (mant % 2) == 1)) mant++;
      if (mant == (longint'(1) << 24)) begin
        mant = mant >> 1;
        p++;
      end
    end
    return {sign, 8'(127 + p), 23'(mant)};
  endfunction

  // Converter model: fixed latency, samples conv_a every edge.
  float_bits_t cpipe [LAT];
  initial for (int s = 0; s < LAT; s++) cpipe[s] = '0;
  always @(posedge clk) begin
    for (int s = LAT - 1; s > 0; s--) cpipe[s] <= cpipe[s-1];
    cpipe[0] <= i2f(conv_a);
  end
  assign conv_result = cpipe[LAT-1];

  // Scoreboard: per-requester queue of expected results (in flight + buffered),
  // so queue size is the requester's outstanding credit use.
  float_bits_t exp_q [NUM_REQ][$];
  int          m_ptr  = 0;
  int_bits_t   m_last = '0;

  always @(negedge clk) begin : monitor
    logic [NUM_REQ-1:0] er;
    int                 g, idx;
    int_bits_t          ea;
    er = '0;
    g  = -1;
    if (reset) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (m_ptr + k) % NUM_REQ;
        if (g < 0 && req_valid[idx] && exp_q[idx].size() < DEPTH) begin
          g       = idx;
          er[idx] = 1'b1;
        end
      end
    end
    ea = !reset ? '0 : ((g >= 0) ? int_bits_t'(req_data[32*g +: 32]) : m_last);
    check("req_ready", 32'(req_ready), 32'(er));
    check("conv_a", conv_a, ea);
    if (!reset) begin
      check("rsp_valid_in_reset", 32'(rsp_valid), 32'd0);
      for (int i = 0; i < NUM_REQ; i++) exp_q[i].delete();
      m_ptr  = 0;
      m_last = '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          if (exp_q[i].size() == 0) check("rsp_unexpected", 32'(rsp_valid[i]), 32'd0);
          else check("rsp_data", rsp_data[32*i +: 32], exp_q[i].pop_front());
        end
      end
      if (g >= 0) begin
        exp_q[g].push_back(i2f(ea));
        m_ptr  = (g + 1) % NUM_REQ;
        m_last = ea;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int r, input int_bits_t v);
    bit ok;
    ok = 1'b0;
    req_valid[r]          = 1'b1;
    req_data[32*r +: 32]  = v;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (req_ready[r]) ok = 1'b1;
      step();
    end
    req_valid[r] = 1'b0;
    check("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    int pending;
    req_valid = '0;
    rsp_ready = '1;
    repeat (LAT + DEPTH + 6) step();
    @(negedge clk);
    pending = 0;
    for (int i = 0; i < NUM_REQ; i++) pending += exp_q[i].size();
    check("drain_rsp_valid", 32'(rsp_valid), 32'd0);
    check("drain_pending", pending, 0);
    step();
  endtask

  typedef struct {
    int          req;
    int_bits_t   a;
    float_bits_t f;
  } vec_t;

  vec_t        vecs [8];
  int_bits_t   seq_in  [4];
  float_bits_t seq_exp [4];
  float_bits_t f100    [NUM_REQ];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n, got, prev, gid, cnt1;
    int acc [NUM_REQ];
    logic [NUM_REQ-1:0] seen;
    bit ok;

    vecs[0] = '{0, 32'sd1,         FLOAT_ONE};
    vecs[1] = '{3, 32'sd100,       32'h42C80000};
    vecs[2] = '{2, -32'sd100,      32'hC2C80000};
    vecs[3] = '{0, 32'sd16777217,  32'h4B800000};
    vecs[4] = '{3, 32'sd16777219,  32'h4B800002};
    vecs[5] = '{1, 32'sh80000000,  32'hCF000000};
    vecs[6] = '{2, 32'sh7FFFFFFF,  32'h4F000000};
    vecs[7] = '{1, 32'sd0,         32'h00000000};
    seq_in  = '{32'shFFFFFFFF, 32'sh80000000, 32'sh7FFFFFFF, 32'sd0};
    seq_exp = '{32'hBF800000, 32'hCF000000, 32'h4F000000, 32'h00000000};
    f100    = '{32'h42C80000, 32'h42CA0000, 32'h42CC0000, 32'h42CE0000};

    reset     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = '1;
    repeat (2) step();
    reset = 1'b1;
    step();

    // Single transactions: latency, routing, conversion values.
    for (int v = 0; v < 8; v++) begin
      send(vecs[v].req, vecs[v].a);
      n   = 0;
      got = 0;
      while (n < 20 && got == 0) begin
        @(posedge clk);
        n++;
        @(negedge clk);
        got = int'(rsp_valid[vecs[v].req]);
      end
      check("vec_latency", n, LAT);
      check("vec_data", rsp_data[32*vecs[v].req +: 32], vecs[v].f);
      check("vec_others_idle", 32'(rsp_valid & ~(NUM_REQ'(1) << vecs[v].req)), 32'd0);
      step();
      drain();
    end

    // Back-to-back stream from requester 1, responses in issue order.
    fork
      begin
        for (int k = 0; k < 4; k++) send(1, seq_in[k]);
      end
      begin
        cnt1 = 0;
        for (int c = 0; c < 80 && cnt1 < 4; c++) begin
          @(negedge clk);
          if (rsp_valid[1]) begin
            check("seq_data", rsp_data[63:32], seq_exp[cnt1]);
            cnt1++;
          end
        end
        check("seq_count", cnt1, 4);
      end
    join
    step();
    drain();

    // All requesters streaming: grants rotate one per cycle.
    for (int i = 0; i < NUM_REQ; i++) req_data[32*i +: 32] = 100 + i;
    req_valid = '1;
    prev = -1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      gid = -1;
      for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) gid = i;
      check("rr_onehot", 32'($countones(req_ready)), 32'd1);
      if (prev >= 0) check("rr_rotate", gid, (prev + 1) % NUM_REQ);
      prev = gid;
      for (int i = 0; i < NUM_REQ; i++)
        if (rsp_valid[i]) check("rr_route", rsp_data[32*i +: 32], f100[i]);
      step();
    end
    drain();

    // Requester 2 stalls its responses: it runs out of credit at DEPTH.
    for (int i = 0; i < NUM_REQ; i++) acc[i] = 0;
    req_valid = '1;
    rsp_ready = 4'b1011;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) if (req_valid[i] && req_ready[i]) acc[i]++;
      step();
    end
    check("credit_req2_accepts", acc[2], DEPTH);
    check("credit_others_run", 32'(acc[0] >= 3 && acc[1] >= 3 && acc[3] >= 3), 32'd1);
    @(negedge clk);
    check("credit_req2_held", 32'(rsp_valid[2]), 32'd1);
    step();
    rsp_ready = '1;
    ok = 1'b0;
    for (int c = 0; c < 8 && !ok; c++) begin
      @(negedge clk);
      if (req_ready[2]) ok = 1'b1;
      step();
    end
    check("credit_req2_regrant", 32'(ok), 32'd1);
    drain();

    // Reset with three operations in flight.
    req_valid = 4'b1011;
    repeat (3) step();
    req_valid = '0;
    reset     = 1'b0;
    step();
    reset = 1'b1;
    seen  = '0;
    for (int c = 0; c < LAT + 5; c++) begin
      @(negedge clk);
      seen |= rsp_valid;
      step();
    end
    check("reset_flush", 32'(seen), 32'd0);
    req_valid = '1;
    @(negedge clk);
    check("reset_first_grant", 32'(req_ready), 32'd1);
    step();
    drain();

    // Randomised traffic against the scoreboard.
    for (int c = 0; c < 600; c++) begin
      req_valid = NUM_REQ'($urandom);
      rsp_ready = NUM_REQ'($urandom | $urandom);
      for (int i = 0; i < NUM_REQ; i++)
        req_data[32*i +: 32] = ($urandom_range(0, 3) == 0) ? $urandom
                              : 32'($urandom_range(0, 2000)) - 32'd1000;
      step();
    end
    drain();

`ifdef INT_TO_FLOAT_ARB_PERF_EN
    reset = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clk);
    check("perf_issue_reset", perf_issue, 32'd0);
    check("perf_block_reset", perf_block, 32'd0);
    step();
    req_valid = '1;
    rsp_ready = '0;
    repeat (11) step();      // 8 grants, then 3 fully credit-blocked cycles
    drain();
    send(0, 32'sd7);
    send(0, 32'sd9);
    @(negedge clk);
    check("perf_issue", perf_issue, 32'd10);
    check("perf_block", perf_block, 32'd3);
    step();
    drain();
    reset = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clk);
    check("perf_issue_cleared", perf_issue, 32'd0);
    check("perf_block_cleared", perf_block, 32'd0);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_to_float_arbiter.md
Name: int_to_float_arbiter

Overview:
- Shares one pipelined int-to-float converter (32-bit signed int in, IEEE-754 single out, fixed LATENCY, no stall input) among NUM_REQ requesters.
- Round-robin arbitration, one issue per cycle.
- Carries a requester tag alongside the converter pipeline and steers each result into a per-requester response FIFO with valid/ready handshake.
- Sits between client blocks and the converter instance; the converter itself is instantiated beside it, not inside.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LATENCY, 3, converter cycles from sampled input to matching result (>=1).
- DEPTH, 2, per-requester response FIFO entries and credit limit (power of 2, >=1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  requester i presents an operand.
- req_data  in  NUM_REQ*32  operand i in bits [32i+31:32i], signed integer.
- req_ready  out  NUM_REQ  one-hot grant; operand i is accepted when req_valid[i] and req_ready[i] are both high at a posedge.
- rsp_valid  out  NUM_REQ  FIFO i is non-empty.
- rsp_data  out  NUM_REQ*32  head of FIFO i, float bits.
- rsp_ready  in  NUM_REQ  requester i pops its FIFO head.
- conv_a  out  32  converter operand.
- conv_result  in  32  converter result.

Behaviour:
- Reset (reset low at posedge):
  - tag pipeline valids cleared;
  - all FIFOs emptied;
  - outstanding counters set to 0;
  - round-robin pointer set to 0;
  - req_ready=0, rsp_valid=0, conv_a=0 while reset is held.
  - Converter results arriving after reset are discarded, because their tags are invalid. This also covers reset mid-operation.
- Eligibility: requester i is eligible when req_valid[i]=1 and outstanding[i] < DEPTH.
  - outstanding[i] counts in-flight tags plus FIFO occupancy, width clog2(DEPTH+1).
- Arbitration (combinational):
  - Grant the first eligible requester scanning from ptr, ptr+1, … wrapping modulo NUM_REQ.
  - req_ready is one-hot or zero; it depends on req_valid (no combinational path from rsp_ready).
  - No eligible requester: req_ready=0, conv_a holds its last value, and the tag inserted is invalid.
- On a grant to g:
  - conv_a = req_data[g] combinationally in the same cycle; the converter samples it at that posedge.
  - ptr <= (g+1) mod NUM_REQ. With no grant, ptr is unchanged.
- Tag pipeline: LATENCY-stage shift register of {valid, id}, advanced every cycle unconditionally.
  - When the last stage is valid, conv_result is written into FIFO[id] at that posedge.
- Latency: accept at edge t -> rsp_valid visible after edge t+LATENCY, i.e. LATENCY+1 cycles from the request cycle. Throughput is 1 result/cycle aggregate.
- Outstanding counter:
  - +1 on grant, -1 on pop;
  - simultaneous grant and pop for the same i leaves it unchanged.
- FIFO:
  - Cannot overflow, by the credit rule; overflow is an assertion.
  - Write and pop in the same cycle on a full or empty FIFO are legal (a write to an empty FIFO is not visible until the next cycle).
  - Results for one requester are returned in issue order.
  - Pop with rsp_valid=0 is ignored.
- Wrap-around: FIFO pointers use clog2(DEPTH)+1 bits, with full/empty derived from the MSB compare.

Optional Feature:
- Macro: INT_TO_FLOAT_ARB_PERF_EN.
- When defined, adds two ports:
  - perf_issue (out, 32): counts cycles with a grant.
  - perf_block (out, 32): counts cycles where some req_valid is high but no grant occurred (all credit-blocked).
- Both counters saturate at 32'hFFFFFFFF and clear on reset.
- When undefined, the ports and logic are absent and the core behaviour is identical.

Decomposition:
- Package int_to_float_pkg holds:
  - typedef float_bits_t (logic [31:0]);
  - typedef int_bits_t;
  - typedef struct tag_t {valid, id};
  - constant FLOAT_ONE = 32'h3F800000, used by benches.
- One sub-module: int_to_float_rsp_fifo (single-clock FIFO, DEPTH entries, 32-bit, synchronous active-low reset), instantiated NUM_REQ times via generate.
- Arbiter and tag pipeline stay in the top module.

Test Plan:
- Single requester 0 sends 32'd1 -> rsp_valid[0] high exactly LATENCY+1 cycles later with rsp_data 32'h3F800000. Other rsp_valid remain 0.
- Requester 1 sends the sequence 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd0 back-to-back -> in-order responses 32'hBF800000, 32'hCF000000, 32'h4F000000, 32'h00000000.
- All 4 requesters hold req_valid with rsp_ready=1 -> grants rotate 0,1,2,3,0,… one per cycle. Each response is routed to the correct requester (operand = 100+i -> float of 100+i).
- Requester 2 rsp_ready=0 while streaming -> req_ready[2] drops after DEPTH=2 accepts while the others keep being granted. Raising rsp_ready pops 2 results and re-enables the grant in the following cycle.
- Assert reset for 1 cycle with 3 operations in flight -> no rsp_valid ever appears for them, all FIFOs are empty, and the first post-reset grant goes to requester 0.
- With INT_TO_FLOAT_ARB_PERF_EN: 10 grants plus 3 fully credit-blocked cycles -> perf_issue=10, perf_block=3. Both read 0 after reset.
